// File: rtl/cordic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cordic_pkg                                                    |
// | Description : Shared constants for the 32-bit pipelined CORDIC rotator.     |
// |               All angles are signed Q3.29 radians. The shift/accumulate     |
// |               stages and the output stage import this package too.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package cordic_pkg;

  localparam int DATA_W = 32;

  localparam logic signed [DATA_W-1:0] CORDIC_PI          = 32'sh6487ED51;
  localparam logic signed [DATA_W-1:0] CORDIC_NEG_PI      = 32'sh9B7812AF;
  localparam logic signed [DATA_W-1:0] CORDIC_HALF_PI     = 32'sh3243F6A9;
  localparam logic signed [DATA_W-1:0] CORDIC_NEG_HALF_PI = 32'shCDBC0957;

  // CORDIC gain 0.607252935 in Q3.29
  localparam logic [DATA_W-1:0] CORDIC_K = 32'd326016437;

endpackage
`default_nettype wire

// File: rtl/cordic_tag_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cordic_tag_delay                                              |
// | Description : Fixed-length shift register for the {valid, neg} result tag.  |
// |               Shifts every clock; the asynchronous reset empties every      |
// |               entry so no stale tag survives a reset.                       |
// | Ports       : clk, rst (async, active-high)                                 |
// |               d_valid, d_neg : tag entering the line                        |
// |               q_valid, q_neg : tag leaving the line, DEPTH clocks later     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module cordic_tag_delay #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d_valid,
  input  logic d_neg,
  output logic q_valid,
  output logic q_neg
);

  // Entry i occupies bits [2i+1:2i] as {valid, neg}; entry 0 is the newest.
  logic [2*DEPTH-1:0] tags;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tags <= '0;
        end else begin
          tags <= {d_valid, d_neg};
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tags <= '0;
        end else begin
          tags <= {tags[2*DEPTH-3:0], d_valid, d_neg};
        end
      end
    end
  endgenerate

  assign q_valid = tags[2*DEPTH-1];
  assign q_neg   = tags[2*DEPTH-2];

endmodule
`default_nettype wire

// File: rtl/cordic_pre_rotate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cordic_pre_rotate                                             |
// | Description : Input stage of the 32-bit pipelined CORDIC rotator. Folds the |
// |               input angle into [-pi/2, +pi/2], seeds x/y/z for the first    |
// |               shift/accumulate stage and delays a {valid, neg} tag so it    |
// |               lines up with the last rotation stage.                        |
// | Ports       : clk, rst (async, active-high)                                 |
// |               in_valid, angle          : input sample (Q3.29 radians)       |
// |               x_out, y_out, z_out      : seeds for stage 1                  |
// |               out_valid                : seeds hold a new sample            |
// |               res_valid, res_neg       : tag aligned with final stage       |
// |               range_err                : sticky out-of-range flag           |
// | Options     : CORDIC_RANGE_CHECK_EN - clamp angles outside [-pi, +pi] and   |
// |               raise range_err; otherwise range_err is tied low.             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module cordic_pre_rotate
  import cordic_pkg::*;
#(
  parameter int                PIPE_DEPTH = 16,
  parameter logic [DATA_W-1:0] K_INIT     = CORDIC_K
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] angle,
  output logic [DATA_W-1:0]        x_out,
  output logic [DATA_W-1:0]        y_out,
  output logic [DATA_W-1:0]        z_out,
  output logic                     out_valid,
  output logic                     res_valid,
  output logic                     res_neg,
  output logic                     range_err
);

  logic signed [DATA_W-1:0] angle_eff;
  logic signed [DATA_W-1:0] z_next;
  logic                     neg_next;
  logic                     neg_q;

`ifdef CORDIC_RANGE_CHECK_EN
  logic out_of_range;

  // Clamp before folding so an over-range angle lands exactly on +/-pi.
  always_comb begin
    angle_eff    = angle;
    out_of_range = 1'b0;
    if (angle > CORDIC_PI) begin
      angle_eff    = CORDIC_PI;
      out_of_range = 1'b1;
    end else if (angle < CORDIC_NEG_PI) begin
      angle_eff    = CORDIC_NEG_PI;
      out_of_range = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (in_valid && out_of_range) begin
      range_err <= 1'b1;
    end
  end
`else
  assign angle_eff = angle;
  assign range_err = 1'b0;
`endif

  // Fold into the convergence range; exactly +/-pi/2 is left alone.
  always_comb begin
    z_next   = angle_eff;
    neg_next = 1'b0;
    if (angle_eff > CORDIC_HALF_PI) begin
      z_next   = angle_eff - CORDIC_PI;
      neg_next = 1'b1;
    end else if (angle_eff < CORDIC_NEG_HALF_PI) begin
      z_next   = angle_eff + CORDIC_PI;
      neg_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out     <= K_INIT;
      y_out     <= '0;
      z_out     <= '0;
      out_valid <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Idle cycles push a clean {0,0} tag into the delay line.
      neg_q     <= in_valid & neg_next;
      if (in_valid) begin
        x_out <= K_INIT;
        y_out <= '0;
        z_out <= z_next;
      end
    end
  end

  cordic_tag_delay #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .d_valid (out_valid),
    .d_neg   (neg_q),
    .q_valid (res_valid),
    .q_neg   (res_neg)
  );

endmodule
`default_nettype wire

// File: doc/cordic_pre_rotate.md
Name: cordic_pre_rotate

Overview:
- Input stage of the 32-bit pipelined CORDIC rotator.
- Accepts a signed angle and folds it into the convergence range [-pi/2, +pi/2].
- Seeds x/y/z for the first shift_accumulate stage.
- Carries a valid/negate tag through a delay line matched to the rotation pipeline depth, so the output stage knows when a result is valid and whether to negate it.

Parameters:
- PIPE_DEPTH, 16: number of shift/accumulate stages downstream; sets the tag delay length (legal 1..31).
- K_INIT, 326016437: CORDIC gain 0.607252935 in Q3.29; reset/seed value for x.

Ports:
- clk  input  1  rising-edge clock shared with all CORDIC stages
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  angle is valid this cycle; no backpressure, pipeline never stalls
- angle  input  32  signed Q3.29 radians; legal range [-pi, +pi]
- x_out  output  32  seed x to first stage (K_INIT when loaded)
- y_out  output  32  seed y to first stage (0 when loaded)
- z_out  output  32  folded angle, signed Q3.29
- out_valid  output  1  x/y/z_out hold a new sample
- res_valid  output  1  out_valid delayed PIPE_DEPTH cycles; aligned with last-stage outputs
- res_neg  output  1  fold flag delayed PIPE_DEPTH cycles; output stage negates x and y when set
- range_err  output  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Constants (Q3.29):
  - PI = 0x6487ED51
  - HALF_PI = 0x3243F6A9
  - -HALF_PI = 0xCDBC0957
- Reset (asynchronous, rst=1, takes effect immediately with no clock edge):
  - x_out=K_INIT, y_out=0, z_out=0
  - out_valid=0, res_valid=0, res_neg=0, range_err=0
  - The entire tag delay line clears.
- Latency:
  - x/y/z_out and out_valid: 1 clk after in_valid.
  - res_valid/res_neg: PIPE_DEPTH+1 clks after in_valid.
- Fold, all compares signed:
  - angle > HALF_PI: z = angle - PI, neg = 1.
  - angle < -HALF_PI: z = angle + PI, neg = 1.
  - Otherwise: z = angle, neg = 0.
  - Exactly ±HALF_PI does not fold.
- Arithmetic: 32-bit two's complement. No overflow is possible for legal input.
- in_valid=1: load x_out=K_INIT, y_out=0, z_out=z; out_valid=1.
- in_valid=0: x/y/z_out hold their previous values; out_valid=0.
- Tag delay line:
  - PIPE_DEPTH-entry shift register of {out_valid, neg}, shifted every clk unconditionally.
  - Back-to-back valid inputs are accepted every cycle with no bubbles.
- Reset mid-operation: all in-flight tags are discarded. The first res_valid after reset release comes only from a new input.

Optional Feature:
- Macro: CORDIC_RANGE_CHECK_EN
- Defined:
  - angle > PI is clamped to PI; angle < -PI is clamped to -PI. Clamping happens before the fold.
  - range_err is set on the clk the offending in_valid sample is captured, and stays set until rst.
  - Out-of-range samples still propagate, with out_valid=1.
- Undefined:
  - No compare logic; range_err is tied to 0.
  - Out-of-range angles fold per the rules above; results are unspecified.

Decomposition:
- cordic_pkg: DATA_W=32, CORDIC_PI, CORDIC_HALF_PI, CORDIC_NEG_HALF_PI, CORDIC_K.
  - Shared with the shift_accumulate stages and the output stage.
- One sub-module, cordic_tag_delay:
  - Parameterised-depth shift register of {valid, neg} with async reset.
  - Reused by the output stage.

Test Plan:
- Reset during activity: assert rst asynchronously between edges -> all outputs return to reset values immediately; the pipeline is fed 3 valids, then rst fires -> res_valid never pulses for them.
- angle=0x00000000 valid -> next clk x_out=326016437, y_out=0, z_out=0, out_valid=1; res_valid=1, res_neg=0 exactly PIPE_DEPTH clks after that.
- angle=0x6487ED51 (pi) -> z_out=0x00000000, neg=1; angle=0x40000000 -> z_out=0xDB7812AF, neg=1.
- Boundaries: angle=0x3243F6A9 -> z_out=0x3243F6A9, neg=0; angle=0xCDBC0957 -> z_out=0xCDBC0957, neg=0.
- Throughput: 20 consecutive valids followed by 5 idle cycles -> res_valid high for exactly 20 consecutive clks, res_neg sequence matching the inputs.
- With CORDIC_RANGE_CHECK_EN: angle=0x70000000 -> z_out=0, neg=1, range_err=1 and stays 1 after further legal inputs until rst. Without the macro: range_err=0 always.
